// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader that fills instruction memory and
// holds the core in reset until a checksum-verified load completes.
// Ports: clk, reset (async, active-low), start pulse, in_data/in_valid/
// in_ready byte handshake, mem_we/mem_addr/mem_wdata memory write port,
// cpu_hold core reset, done/error load status.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int MAX_WORDS = 2 ** ADDR_W;
  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state;
  state_t nxt;

  logic [15:0]     count;
  logic [ADDR_W:0] index;
  logic [1:0]      nbyte;
  logic [23:0]     wbuf;
  logic [7:0]      csum;

  logic        fire;
  logic [15:0] full_cnt;
  logic [16:0] idx_inc;

  assign fire     = in_valid && in_ready;
  assign full_cnt = {in_data, count[7:0]};
  // Extra index bit lets a full-capacity load reach MAX_WORDS
  // without the index wrapping back to 0.
  assign idx_inc  = 17'(index) + 17'd1;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) nxt = S_HDR0;
      end
      S_HDR0: begin
        if (fire) nxt = S_HDR1;
      end
      S_HDR1: begin
        if (fire) begin
          if ({1'b0, full_cnt} > MAX_W) nxt = S_ERROR;
          else if (full_cnt == 16'd0)  nxt = S_CSUM;
          else                         nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (fire && nbyte == 2'd3) nxt = S_WRITE;
      end
      S_WRITE: begin
        nxt = (idx_inc == {1'b0, count}) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (fire) nxt = (in_data == csum) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: begin
        if (start) nxt = S_HDR0;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      count     <= '0;
      index     <= '0;
      nbyte     <= '0;
      wbuf      <= '0;
      csum      <= '0;
    end else begin
      state    <= nxt;
      // Status outputs are decoded from the next state so they
      // line up with the state register.
      in_ready <= (nxt == S_HDR0) || (nxt == S_HDR1) ||
                  (nxt == S_DATA) || (nxt == S_CSUM);
      mem_we   <= (nxt == S_WRITE);
      cpu_hold <= (nxt != S_DONE);
      done     <= (nxt == S_DONE);
      error    <= (nxt == S_ERROR);

      unique case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            index <= '0;
            csum  <= '0;
            nbyte <= '0;
          end
        end
        S_HDR0: begin
          if (fire) count[7:0] <= in_data;
        end
        S_HDR1: begin
          if (fire) count[15:8] <= in_data;
        end
        S_DATA: begin
          if (fire) begin
            wbuf  <= {in_data, wbuf[23:8]};
            csum  <= csum ^ in_data;
            nbyte <= nbyte + 2'd1;
            if (nbyte == 2'd3) begin
              mem_addr  <= index[ADDR_W-1:0];
              mem_wdata <= {in_data, wbuf};
            end
          end
        end
        S_WRITE: begin
          index <= index + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed checks of imem_loader
// against a stream-level reference model.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;
  int wr_ready_bad = 0;

  logic [7:0]  got_addr[$];
  logic [31:0] got_data[$];
  logic [7:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_used;

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && mem_we) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
      if (in_ready) wr_ready_bad++;
    end
  end

  // Reference: parse the stream as a whole and list the writes
  // and final status a correct loader must produce.
  task automatic model(input bq_t s);
    int n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    n = int'(s[0]) + 256 * int'(s[1]);
    exp_done = 0;
    exp_err  = 0;
    if (n > 256) begin
      exp_err  = 1;
      exp_used = 2;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      logic [31:0] word;
      word = 32'(s[2+4*w]) + (32'(s[3+4*w]) << 8) +
             (32'(s[4+4*w]) << 16) + (32'(s[5+4*w]) << 24);
      for (int k = 0; k < 4; k++) x = x ^ s[2+4*w+k];
      exp_addr.push_back(8'(w));
      exp_data.push_back(word);
    end
    exp_used = 3 + 4 * n;
    if (s[2+4*n] == x) exp_done = 1;
    else               exp_err  = 1;
  endtask

  function automatic bq_t make_stream(input int n, input bit bad);
    bq_t s;
    logic [7:0] x;
    logic [7:0] b;
    s.push_back(8'(n));
    s.push_back(8'(n >> 8));
    if (n <= 256) begin
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        x = x ^ b;
        s.push_back(b);
      end
      if (bad) x = x ^ 8'($urandom_range(1, 255));
      s.push_back(x);
    end
    return s;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_stream(input bq_t s, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap) @(negedge clk);
      send_byte(s[i]);
    end
  endtask

  task automatic clear_got();
    got_addr.delete();
    got_data.delete();
    wr_ready_bad = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cpu_hold, in_ready, mem_we, done, error} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_state hold/rdy/we/done/err=%b required 10000",
               {cpu_hold, in_ready, mem_we, done, error});
    end
    vectors++;
    if ({mem_addr, mem_wdata} !== 40'd0) begin
      miscompares++;
      $display("FAIL reset_mem addr=%h data=%h required 0", mem_addr,
               mem_wdata);
    end
  endtask

  task automatic test_basic();
    bq_t s;
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
    clear_got();
    pulse_start();
    send_stream(s, s.size(), 0);
    vectors++;
    if (got_addr.size() != 2) begin
      miscompares++;
      $display("FAIL basic_nwr got=%0d required 2", got_addr.size());
    end else begin
      vectors++;
      if (got_addr[0] !== 8'd0 || got_data[0] !== 32'h00500013) begin
        miscompares++;
        $display("FAIL basic_wr0 %h:%h required 00:00500013",
                 got_addr[0], got_data[0]);
      end
      vectors++;
      if (got_addr[1] !== 8'd1 || got_data[1] !== 32'h00100093) begin
        miscompares++;
        $display("FAIL basic_wr1 %h:%h required 01:00100093",
                 got_addr[1], got_data[1]);
      end
    end
    vectors++;
    if ({done, error, cpu_hold, in_ready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL basic_final done/err/hold/rdy=%b required 1000",
               {done, error, cpu_hold, in_ready});
    end
    vectors++;
    if (mem_addr !== 8'd1 || mem_wdata !== 32'h00100093) begin
      miscompares++;
      $display("FAIL basic_hold_mem %h:%h required 01:00100093",
               mem_addr, mem_wdata);
    end
  endtask

  task automatic test_bad_csum();
    bq_t s;
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'hC1};
    clear_got();
    pulse_start();
    vectors++;
    if (done !== 1'b0 || cpu_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_clear done=%b hold=%b required 0 1",
               done, cpu_hold);
    end
    send_stream(s, s.size(), 0);
    vectors++;
    if (got_addr.size() != 2) begin
      miscompares++;
      $display("FAIL badcs_nwr got=%0d required 2", got_addr.size());
    end
    vectors++;
    if ({done, error, cpu_hold} !== 3'b011) begin
      miscompares++;
      $display("FAIL badcs_final done/err/hold=%b required 011",
               {done, error, cpu_hold});
    end
    s[10] = 8'hC0;
    pulse_start();
    vectors++;
    if (error !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear error=%b required 0", error);
    end
    send_stream(s, s.size(), 0);
    vectors++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      miscompares++;
      $display("FAIL badcs_retry done/err/hold=%b required 100",
               {done, error, cpu_hold});
    end
  endtask

  task automatic test_empty_oversize();
    bq_t s;
    s = '{8'h00, 8'h00, 8'h00};
    clear_got();
    pulse_start();
    send_stream(s, 3, 0);
    vectors++;
    if (got_addr.size() != 0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL empty nwr=%0d done=%b required 0 1",
               got_addr.size(), done);
    end
    s = '{8'h01, 8'h01};
    pulse_start();
    send_stream(s, 2, 0);
    vectors++;
    if ({error, done, cpu_hold, in_ready} !== 4'b1010) begin
      miscompares++;
      $display("FAIL oversize err/done/hold/rdy=%b required 1010",
               {error, done, cpu_hold, in_ready});
    end
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || error !== 1'b1) begin
        miscompares++;
        $display("FAIL oversize_idle rdy=%b err=%b required 0 1",
                 in_ready, error);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stalls();
    bq_t s;
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
    clear_got();
    pulse_start();
    send_stream(s, s.size(), 3);
    vectors++;
    if (got_addr.size() != 2 || got_data[0] !== 32'h00500013 ||
        got_data[1] !== 32'h00100093 || got_addr[1] !== 8'd1) begin
      miscompares++;
      $display("FAIL stall_writes nwr=%0d", got_addr.size());
    end
    vectors++;
    if (wr_ready_bad != 0) begin
      miscompares++;
      $display("FAIL stall_write_ready count=%0d required 0", wr_ready_bad);
    end
    vectors++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      miscompares++;
      $display("FAIL stall_final done/err/hold=%b required 100",
               {done, error, cpu_hold});
    end
  endtask

  task automatic test_reset_midload();
    bq_t s;
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
    pulse_start();
    send_stream(s, 6, 0);
    reset = 1'b0;
    #1;
    vectors++;
    if ({cpu_hold, in_ready, mem_we, done} !== 4'b1000) begin
      miscompares++;
      $display("FAIL midreset hold/rdy/we/done=%b required 1000",
               {cpu_hold, in_ready, mem_we, done});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_idle rdy=%b hold=%b required 0 1",
               in_ready, cpu_hold);
    end
    clear_got();
    pulse_start();
    send_stream(s, s.size(), 0);
    vectors++;
    if (done !== 1'b1 || got_addr.size() != 2) begin
      miscompares++;
      $display("FAIL midreset_reload done=%b nwr=%0d required 1 2",
               done, got_addr.size());
    end
  endtask

  task automatic test_random();
    bq_t s;
    int n;
    int bad_wr;
    for (int it = 0; it < 8; it++) begin
      if (it == 2)      n = 256;
      else if (it == 5) n = $urandom_range(257, 65535);
      else              n = $urandom_range(1, 6);
      s = make_stream(n, $urandom_range(0, 2) == 0);
      model(s);
      clear_got();
      pulse_start();
      for (int i = 0; i < exp_used; i++) begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
        send_byte(s[i]);
        // A start pulse mid-load must not restart it.
        if (i == 3 && exp_used > 4) pulse_start();
      end
      vectors++;
      if (got_addr.size() != exp_addr.size()) begin
        miscompares++;
        $display("FAIL rand_nwr it=%0d got=%0d required %0d",
                 it, got_addr.size(), exp_addr.size());
      end else begin
        bad_wr = 0;
        foreach (exp_addr[i])
          if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
            bad_wr++;
        vectors++;
        if (bad_wr != 0) begin
          miscompares++;
          $display("FAIL rand_writes it=%0d bad=%0d required 0", it, bad_wr);
        end
      end
      vectors++;
      if (done !== exp_done || error !== exp_err ||
          cpu_hold !== !exp_done) begin
        miscompares++;
        $display("FAIL rand_final it=%0d done/err/hold=%b%b%b required %b%b%b",
                 it, done, error, cpu_hold, exp_done, exp_err, !exp_done);
      end
      vectors++;
      if (wr_ready_bad != 0) begin
        miscompares++;
        $display("FAIL rand_write_ready it=%0d count=%0d required 0",
                 it, wr_ready_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_empty_oversize();
    test_stalls();
    test_reset_midload();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream program loader that writes 32-bit instruction words into the instruction memory that the single-cycle datapath fetches from.
- Holds the datapath in reset while loading; releases it only after a checksum-verified load completes.
- Sits between a host byte source (UART receiver or bench driver) and the instruction-memory write port.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity MAX_WORDS = 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR
in_data  input  8  incoming stream byte
in_valid  input  1  in_data is valid
in_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction-memory write enable, one-cycle pulse
mem_addr  output  ADDR_W  word address of the write
mem_wdata  output  32  instruction word
cpu_hold  output  1  high = datapath held in reset
done  output  1  load completed, checksum good
error  output  1  load aborted (bad count or checksum)

Behaviour:
- Stream format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then 4*N data bytes, then 1 checksum byte.
  - Each word is assembled little-endian: the first byte goes to [7:0].
  - Checksum = XOR of all data bytes only; header bytes are excluded.
- A byte transfers on a rising edge when in_valid && in_ready. in_data is ignored otherwise.
- Reset (async, reset=0): state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0. Word index, byte counter and checksum accumulator are all cleared.
- States and transitions:
  - IDLE: in_ready=0. start -> HDR0, with index, checksum and done/error cleared.
  - HDR0: in_ready=1. Accept byte -> count[7:0], then go to HDR1.
  - HDR1: in_ready=1. Accept byte -> count[15:8]. Next state depends on the full count:
    - count > MAX_WORDS -> ERROR.
    - count == 0 -> CSUM.
    - otherwise -> DATA.
  - DATA: in_ready=1.
    - Each accepted byte is shifted into the word buffer and XORed into the checksum.
    - The 4th byte of a word -> WRITE.
  - WRITE: in_ready=0 for exactly one cycle.
    - mem_we=1, mem_addr=index, mem_wdata=the assembled word.
    - Next edge: index++. If index+1 == count -> CSUM, else -> DATA.
  - CSUM: in_ready=1. Accepted byte == accumulator -> DONE, else -> ERROR.
  - DONE: in_ready=0, done=1, cpu_hold=0. start -> HDR0, which reasserts cpu_hold and clears done.
  - ERROR: in_ready=0, error=1, cpu_hold=1. start -> HDR0.
- Outputs are registered. mem_addr and mem_wdata hold their last written value when mem_we=0.
- cpu_hold=1 in every state except DONE.
- start outside IDLE/DONE/ERROR is ignored; a load in progress is not restarted.
- Stalls: in_valid=0 for any number of cycles pauses the load in its current state; nothing is lost.
- Index wrap: with count == MAX_WORDS, the final write is at address MAX_WORDS-1. The index never wraps to 0 during a load.
- Reset mid-load: returns to IDLE immediately. Partially written memory is not cleared; cpu_hold=1.
- Throughput: 5 cycles per word minimum (4 byte beats + 1 WRITE).

Test Plan:
1. Reset with reset=0, then release, no start -> cpu_hold=1, in_ready=0, mem_we=0, done=0, error=0.
2. start; stream 02 00, 13 00 50 00, 93 00 10 00, C0 with in_valid held high -> mem_we pulses at addr 0 (0x00500013) and addr 1 (0x00100093); then done=1 and cpu_hold=0.
3. Same stream with checksum byte C1 -> both writes occur, then error=1, cpu_hold=1, done=0; a second start plus the correct stream -> done=1.
4. Header 00 00, checksum 00 -> no mem_we; done=1. Header 01 01 (257 > 256 at ADDR_W=8) -> error=1 immediately after HDR1, and no checksum byte is consumed.
5. Scenario 2 with in_valid low for 3 cycles between every byte -> identical writes and final state; in_ready=0 during each WRITE cycle.
6. Drop reset after the 6th byte of scenario 2 -> IDLE, cpu_hold=1, in_ready=0; a subsequent start and full stream completes with done=1.
